// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the asynchronous RAM and its read master.
package ram_pkg;
   localparam int RAM_ADDR_W = 5;
   localparam int RAM_DATA_W = 32;
   localparam int RAM_DEPTH  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } rd_state_t;
endpackage

// File: rtl/ram_async.sv
// 2^ADDR_W x DATA_W RAM: synchronous write, combinational read on the shared address.
module ram_async
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] address,
   input  logic              writeOn,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (writeOn) mem[address] <= data_in;
   end

   assign data_out = mem[address];

endmodule

// File: rtl/ram_async_reader.sv
// Sequential wrap-around read master for ram_async; streams words on valid/ready
// and keeps a running checksum of accepted words.
//
//  state | meaning
//  IDLE  | waiting for start; address and checksum hold
//  READ  | address driven, RAM word captured at the edge
//  HOLD  | captured word offered on out_valid until accepted
//  DONE  | one-cycle done pulse, then back to IDLE
module ram_async_reader
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] address,
   output logic              writeOn,
   input  logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

   rd_state_t       state, next_state;
   logic [ADDR_W:0] remaining;
   logic            accept;
   logic            last_word;

   assign last_word = (remaining == ONE_CNT);
   assign accept    = (state == HOLD) && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (start) next_state = (count != '0) ? READ : DONE;
         READ: next_state = HOLD;
         HOLD: if (out_ready) next_state = last_word ? DONE : READ;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Counts above the RAM depth are clamped so a sweep never revisits a word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address   <= '0;
         remaining <= '0;
         out_data  <= '0;
         checksum  <= '0;
      end else begin
         if (state == IDLE && start) begin
            checksum <= '0;
            if (count != '0) begin
               address   <= base_addr;
               remaining <= (count > MAX_CNT) ? MAX_CNT : count;
            end
         end
         if (state == READ) out_data <= data_out;
         if (accept) begin
            checksum  <= checksum + out_data;
            remaining <= remaining - ONE_CNT;
            if (!last_word) address <= address + ADDR_W'(1);
         end
      end
   end

   assign writeOn   = 1'b0;
   assign out_valid = (state == HOLD);
   assign out_last  = (state == HOLD) && last_word;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule
